abajo_proc_unit: RTL and testbench

//  8-bit datapath of the 18-bit-instruction soft processor, steered cycle by cycle by the external control FSM.
//  - Holds the instruction register (IR) and an 8x8 register file.
//  - Contains the ALU with its carry and zero flags, and the writeback mux.
//  - Exports decoded instruction fields and the flags to the control FSM.

---
 rtl/abajo_proc_unit.sv | 263 ++++++++++++++++++++++++++
 tb/tb_abajo_proc_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abajo_proc_unit.sv
// -----------------------------------------------------------------------------
// abajo_proc_unit
//   8-bit datapath of the 18-bit-instruction soft processor. The external
//   control FSM steers it cycle by cycle. It holds the instruction register,
//   an 8x8 register file, the ALU with its carry/zero flags and the
//   writeback mux. It also exports the decoded instruction fields and the
//   flags back to the FSM.
//
// Ports
//   clk_i       in   1   clock, rising edge
//   rst_i       in   1   asynchronous reset, active low
//   ClkEn_e     in   1   clock enable; 0 freezes all state
//   inst_dat_i  in   18  instruction word
//   inst_ack_i  in   1   instruction valid; loads IR
//   data_dat_i  in   8   data-memory read data (writeback source)
//   port_dat_i  in   8   I/O port read data (writeback source)
//   RegMux_c    in   2   writeback select: ALU / data / port / IR[7:0]
//   RegWrt_c    in   1   register-file write enable
//   op2_c       in   1   ALU operand B: 0 immediate IR[7:0], 1 R[IR[4:2]]
//   ALUOp_c     in   4   ALU operation
//   op_e        out  3   IR[16:14]
//   func_e      out  3   IR[2:0]
//   addr_e      out  12  IR[11:0]
//   disp_e      out  8   IR[7:0]
//   offset_e    out  8   IR[7:0]
//   rs_o        out  8   R[IR[10:8]], combinational
//   carry_e     out  1   carry flag
//   zero_e      out  1   zero flag
// -----------------------------------------------------------------------------

// Register file: one synchronous write port, two asynchronous read ports.
//   clk_i/rst_i  clock, async active-low reset
//   we_i         write enable (already qualified with the clock enable)
//   wa_i/wd_i    write address / data
//   ra_a_i/ra_b_i, rd_a_o/rd_b_o  read addresses / data
module abajo_proc_unit_regfile (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [2:0] wa_i,
  input  logic [7:0] wd_i,
  input  logic [2:0] ra_a_i,
  input  logic [2:0] ra_b_i,
  output logic [7:0] rd_a_o,
  output logic [7:0] rd_b_o
);

  logic [7:0] mem [0:7];

  // NOTE: the array is reset explicitly because software relies on every
  // register reading 0 after reset; this forces flops rather than RAM macros.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else if (we_i) begin
      mem[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = mem[ra_a_i];
  assign rd_b_o = mem[ra_b_i];

endmodule

module abajo_proc_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ClkEn_e,
  input  logic [17:0] inst_dat_i,
  input  logic        inst_ack_i,
  input  logic [7:0]  data_dat_i,
  input  logic [7:0]  port_dat_i,
  input  logic [1:0]  RegMux_c,
  input  logic        RegWrt_c,
  input  logic        op2_c,
  input  logic [3:0]  ALUOp_c,
  output logic [2:0]  op_e,
  output logic [2:0]  func_e,
  output logic [11:0] addr_e,
  output logic [7:0]  disp_e,
  output logic [7:0]  offset_e,
  output logic [7:0]  rs_o,
  output logic        carry_e,
  output logic        zero_e
);

  localparam logic [1:0] MUX_ALU  = 2'b00;
  localparam logic [1:0] MUX_DATA = 2'b01;
  localparam logic [1:0] MUX_PORT = 2'b10;
  localparam logic [1:0] MUX_IMM  = 2'b11;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_ADDC   = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_SUBC   = 4'b0011;
  localparam logic [3:0] OP_AND    = 4'b0100;
  localparam logic [3:0] OP_OR     = 4'b0101;
  localparam logic [3:0] OP_XOR    = 4'b0110;
  localparam logic [3:0] OP_ANDNOT = 4'b0111;
  localparam logic [3:0] OP_SHL    = 4'b1000;
  localparam logic [3:0] OP_SHR    = 4'b1001;
  localparam logic [3:0] OP_ROL    = 4'b1010;
  localparam logic [3:0] OP_ROR    = 4'b1011;

  logic [17:0] ir_q;
  logic        carry_q;
  logic        zero_q;

  // Instruction fields
  logic [2:0] rd_sel;
  logic [2:0] rs_sel;
  logic [2:0] rs2_sel;
  logic [7:0] imm;
  logic [2:0] cnt;

  assign rd_sel  = ir_q[13:11];
  assign rs_sel  = ir_q[10:8];
  assign rs2_sel = ir_q[4:2];
  assign imm     = ir_q[7:0];
  assign cnt     = ir_q[7:5];

  logic [7:0] op_a;
  logic [7:0] rs2_val;
  logic [7:0] op_b;
  logic [7:0] wb_data;
  logic       reg_we;

  assign reg_we = ClkEn_e & RegWrt_c;

  abajo_proc_unit_regfile registers (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (reg_we),
    .wa_i   (rd_sel),
    .wd_i   (wb_data),
    .ra_a_i (rs_sel),
    .ra_b_i (rs2_sel),
    .rd_a_o (op_a),
    .rd_b_o (rs2_val)
  );

  assign op_b = op2_c ? rs2_val : imm;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  // Carry-in only participates in addc/subc.
  logic       cin;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [15:0] shl_w;
  logic [15:0] shr_w;
  logic [15:0] rol_w;
  logic [15:0] ror_w;

  assign cin   = (ALUOp_c == OP_ADDC || ALUOp_c == OP_SUBC) ? carry_q : 1'b0;
  assign sum9  = {1'b0, op_a} + {1'b0, op_b} + {8'h00, cin};
  // Bit 8 of the 9-bit difference is the borrow out.
  assign diff9 = {1'b0, op_a} - {1'b0, op_b} - {8'h00, cin};
  // Shifts are done in a 16-bit window so the last bit shifted out lands at a
  // fixed position next to the result; for cnt=0 that position holds 0.
  assign shl_w = {8'h00, op_a} << cnt;
  assign shr_w = {op_a, 8'h00} >> cnt;
  assign rol_w = {op_a, op_a} << cnt;
  assign ror_w = {op_a, op_a} >> cnt;

  logic [7:0] alu_res;
  logic       alu_carry;
  logic       alu_zero;

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    alu_res   = 8'h00;
    alu_carry = 1'b0;
    unique case (ALUOp_c)
      OP_ADD, OP_ADDC: begin
        alu_res   = sum9[7:0];
        alu_carry = sum9[8];
      end
      OP_SUB, OP_SUBC: begin
        alu_res   = diff9[7:0];
        alu_carry = diff9[8];
      end
      OP_AND:    alu_res = op_a & op_b;
      OP_OR:     alu_res = op_a | op_b;
      OP_XOR:    alu_res = op_a ^ op_b;
      OP_ANDNOT: alu_res = op_a & ~op_b;
      OP_SHL: begin
        alu_res   = shl_w[7:0];
        alu_carry = shl_w[8];
      end
      OP_SHR: begin
        alu_res   = shr_w[15:8];
        alu_carry = shr_w[7];
      end
      OP_ROL: begin
        alu_res   = rol_w[15:8];
        alu_carry = (cnt != 3'd0) & rol_w[8];
      end
      OP_ROR: begin
        alu_res   = ror_w[7:0];
        alu_carry = (cnt != 3'd0) & ror_w[7];
      end
      default: begin
        alu_res   = 8'h00;
        alu_carry = 1'b0;
      end
    endcase
  end

  assign alu_zero = (alu_res == 8'h00);

  // Writeback source select
  always_comb begin
    wb_data = alu_res;
    unique case (RegMux_c)
      MUX_ALU:  wb_data = alu_res;
      MUX_DATA: wb_data = data_dat_i;
      MUX_PORT: wb_data = port_dat_i;
      MUX_IMM:  wb_data = imm;
      default:  wb_data = alu_res;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State: IR and flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; this is what lets a write use the old IR while the IR
  // loads a new word on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ir_q <= 18'h0_0000;
    end else if (ClkEn_e && inst_ack_i) begin
      ir_q <= inst_dat_i;
    end
  end

  // Flags follow only ALU writebacks; loads and port reads leave them alone.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (reg_we && RegMux_c == MUX_ALU) begin
      carry_q <= alu_carry;
      zero_q  <= alu_zero;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs to the control FSM
  // ---------------------------------------------------------------------------
  assign op_e     = ir_q[16:14];
  assign func_e   = ir_q[2:0];
  assign addr_e   = ir_q[11:0];
  assign disp_e   = ir_q[7:0];
  assign offset_e = ir_q[7:0];
  assign rs_o     = op_a;
  assign carry_e  = carry_q;
  assign zero_e   = zero_q;

endmodule

// File: tb/tb_abajo_proc_unit.sv
// -----------------------------------------------------------------------------
// tb_abajo_proc_unit
//   Self-checking bench for abajo_proc_unit. A behavioural model keeps the
//   register file, IR and flags as plain integers and applies the instruction
//   rules arithmetically. Directed sequences cover reset, add/sub carry
//   chains, shifts and the clock-enable freeze; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_abajo_proc_unit;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic [17:0] inst_dat;
  logic        inst_ack;
  logic [7:0]  data_dat;
  logic [7:0]  port_dat;
  logic [1:0]  reg_mux;
  logic        reg_wrt;
  logic        op2;
  logic [3:0]  alu_op;
  logic [2:0]  op_e;
  logic [2:0]  func_e;
  logic [11:0] addr_e;
  logic [7:0]  disp_e;
  logic [7:0]  offset_e;
  logic [7:0]  rs_o;
  logic        carry_e;
  logic        zero_e;

  abajo_proc_unit dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .ClkEn_e    (clk_en),
    .inst_dat_i (inst_dat),
    .inst_ack_i (inst_ack),
    .data_dat_i (data_dat),
    .port_dat_i (port_dat),
    .RegMux_c   (reg_mux),
    .RegWrt_c   (reg_wrt),
    .op2_c      (op2),
    .ALUOp_c    (alu_op),
    .op_e       (op_e),
    .func_e     (func_e),
    .addr_e     (addr_e),
    .disp_e     (disp_e),
    .offset_e   (offset_e),
    .rs_o       (rs_o),
    .carry_e    (carry_e),
    .zero_e     (zero_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          ref_r [8];
  int          ref_c;
  int          ref_z;
  logic [17:0] ref_ir;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) ref_r[i] = 0;
    ref_c  = 0;
    ref_z  = 0;
    ref_ir = '0;
  endfunction

  function automatic void model_alu(input int op, input int a, input int b, input int cin,
                                    input int cnt, output int res, output int c);
    int t;
    res = 0;
    c   = 0;
    case (op)
      0:  begin t = a + b;       res = t % 256;         c = (t > 255); end
      1:  begin t = a + b + cin; res = t % 256;         c = (t > 255); end
      2:  begin t = a - b;       res = (t + 512) % 256; c = (t < 0);   end
      3:  begin t = a - b - cin; res = (t + 512) % 256; c = (t < 0);   end
      4:  res = a & b;
      5:  res = a | b;
      6:  res = a ^ b;
      7:  res = a & (~b & 255);
      8:  begin
            res = (a * (1 << cnt)) % 256;
            c   = (cnt == 0) ? 0 : ((a >> (8 - cnt)) & 1);
          end
      9:  begin
            res = a / (1 << cnt);
            c   = (cnt == 0) ? 0 : ((a >> (cnt - 1)) & 1);
          end
      10: begin
            res = ((a << cnt) | (a >> (8 - cnt))) & 255;
            c   = (cnt == 0) ? 0 : (res & 1);
          end
      11: begin
            res = ((a >> cnt) | (a << (8 - cnt))) & 255;
            c   = (cnt == 0) ? 0 : ((res >> 7) & 1);
          end
      default: begin res = 0; c = 0; end
    endcase
  endfunction

  // Apply one clock edge worth of behaviour to the model (pre-edge values).
  function automatic void model_edge(input bit en, input bit ack, input logic [17:0] word,
                                     input bit wrt, input int mux, input bit use_rs2,
                                     input int op, input int dat, input int prt);
    int rd, rs, rs2, imm, cnt, a, b, res, c, wb;
    if (!en) return;
    rd  = int'(ref_ir[13:11]);
    rs  = int'(ref_ir[10:8]);
    rs2 = int'(ref_ir[4:2]);
    imm = int'(ref_ir[7:0]);
    cnt = int'(ref_ir[7:5]);
    if (wrt) begin
      a = ref_r[rs];
      b = use_rs2 ? ref_r[rs2] : imm;
      model_alu(op, a, b, ref_c, cnt, res, c);
      case (mux)
        0:       wb = res;
        1:       wb = dat;
        2:       wb = prt;
        default: wb = imm;
      endcase
      ref_r[rd] = wb;
      if (mux == 0) begin
        ref_c = c;
        ref_z = (res == 0);
      end
    end
    if (ack) ref_ir = word;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic [17:0] mk(input int op3, input int rd, input int rs, input int imm);
    logic [17:0] w;
    w = {1'b0, 3'(op3), 3'(rd), 3'(rs), 8'(imm)};
    return w;
  endfunction

  task automatic verify(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(dut.registers.mem[i]), ref_r[i]);
    check({tag, "_carry"}, 32'(carry_e), ref_c);
    check({tag, "_zero"},  32'(zero_e),  ref_z);
    check({tag, "_op"},    32'(op_e),    32'(ref_ir[16:14]));
    check({tag, "_func"},  32'(func_e),  32'(ref_ir[2:0]));
    check({tag, "_addr"},  32'(addr_e),  32'(ref_ir[11:0]));
    check({tag, "_disp"},  32'(disp_e),  32'(ref_ir[7:0]));
    check({tag, "_offs"},  32'(offset_e), 32'(ref_ir[7:0]));
    check({tag, "_rs"},    32'(rs_o),    ref_r[int'(ref_ir[10:8])]);
  endtask

  // Drive one cycle at the falling edge, clock it, then check at the next
  // falling edge.
  task automatic step(input string tag, input bit en, input bit ack, input logic [17:0] word,
                      input bit wrt, input logic [1:0] mux, input bit use_rs2,
                      input logic [3:0] op);
    logic [7:0] dat;
    logic [7:0] prt;
    dat      = 8'($urandom);
    prt      = 8'($urandom);
    clk_en   = en;
    inst_ack = ack;
    inst_dat = word;
    reg_wrt  = wrt;
    reg_mux  = mux;
    op2      = use_rs2;
    alu_op   = op;
    data_dat = dat;
    port_dat = prt;
    model_edge(en, ack, word, wrt, int'(mux), use_rs2, int'(op), int'(dat), int'(prt));
    @(posedge clk);
    @(negedge clk);
    inst_ack = 1'b0;
    reg_wrt  = 1'b0;
    verify(tag);
  endtask

  // Fetch then execute with writeback.
  task automatic run(input string tag, input logic [17:0] word, input logic [3:0] op,
                     input bit use_rs2, input logic [1:0] mux);
    step({tag, "_f"}, 1'b1, 1'b1, word, 1'b0, mux, use_rs2, op);
    step({tag, "_x"}, 1'b1, 1'b0, word, 1'b1, mux, use_rs2, op);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n    = 1'b0;
    clk_en   = 1'b0;
    inst_dat = '0;
    inst_ack = 1'b0;
    data_dat = '0;
    port_dat = '0;
    reg_mux  = '0;
    reg_wrt  = 1'b0;
    op2      = 1'b0;
    alu_op   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    verify("rst0");
    rst_n = 1'b1;

    // Put some state in, then hit reset between edges.
    run("pre1", mk(5, 6, 0, 8'hA5), 4'd0, 1'b0, 2'b11);
    run("pre2", mk(7, 3, 6, 8'h12), 4'd0, 1'b0, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_op",  32'(op_e), 32'd0);
    check("mid_rst_rs",  32'(rs_o), 32'd0);
    check("mid_rst_r6",  32'(dut.registers.mem[6]), 32'd0);
    check("mid_rst_c",   32'(carry_e), 32'd0);
    verify("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // sub r0,r0,r0 ; addi r1,r0,100 ; addi r2,r0,200 ; add r3,r1,r2
    run("sub0",  mk(1, 0, 0, 0),   4'd2, 1'b1, 2'b00);
    run("addi1", mk(1, 1, 0, 100), 4'd0, 1'b0, 2'b00);
    run("addi2", mk(1, 2, 0, 200), 4'd0, 1'b0, 2'b00);
    run("add3",  mk(1, 3, 1, 2 << 2), 4'd0, 1'b1, 2'b00);
    check("t2_r3",    32'(dut.registers.mem[3]), 32'h2C);
    check("t2_carry", 32'(carry_e), 32'd1);
    check("t2_zero",  32'(zero_e),  32'd0);

    // addci r4,r0,255 with C=1 ; subc r5,r0,r4
    run("addci4", mk(2, 4, 0, 255), 4'd1, 1'b0, 2'b00);
    check("t3_r4",    32'(dut.registers.mem[4]), 32'h00);
    check("t3_carry", 32'(carry_e), 32'd1);
    check("t3_zero",  32'(zero_e),  32'd1);
    run("subc5", mk(2, 5, 0, 4 << 2), 4'd3, 1'b1, 2'b00);
    check("t3_r5",     32'(dut.registers.mem[5]), 32'hFF);
    check("t3_carry2", 32'(carry_e), 32'd1);

    // add r0,r0,r0 ; subc r5,r0,r4
    run("add0", mk(2, 0, 0, 0), 4'd0, 1'b1, 2'b00);
    check("t4_carry", 32'(carry_e), 32'd0);
    check("t4_zero",  32'(zero_e),  32'd1);
    run("subc5b", mk(2, 5, 0, 4 << 2), 4'd3, 1'b1, 2'b00);
    check("t4_r5",   32'(dut.registers.mem[5]), 32'h00);
    check("t4_zero2", 32'(zero_e), 32'd1);

    // R1=0x81 ; shr r2,r1,1 ; andnot 0xF0 & ~0x3C
    run("ldi1",  mk(3, 1, 0, 8'h81), 4'd0, 1'b0, 2'b11);
    run("shr2",  mk(4, 2, 1, 8'h20), 4'd9, 1'b0, 2'b00);
    check("t5_r2",    32'(dut.registers.mem[2]), 32'h40);
    check("t5_carry", 32'(carry_e), 32'd1);
    run("ldi1b", mk(3, 1, 0, 8'hF0), 4'd0, 1'b0, 2'b11);
    run("ldi2",  mk(3, 2, 0, 8'h3C), 4'd0, 1'b0, 2'b11);
    run("andn3", mk(4, 3, 1, 2 << 2), 4'd7, 1'b1, 2'b00);
    check("t5_r3", 32'(dut.registers.mem[3]), 32'hC0);

    // Clock enable low: nothing moves.
    step("frz", 1'b0, 1'b1, mk(6, 3, 3, 8'h55), 1'b1, 2'b11, 1'b0, 4'd0);
    check("t6_r3", 32'(dut.registers.mem[3]), 32'hC0);
    check("t6_op", 32'(op_e), 32'd4);

    // Write and IR load on the same edge: write uses the old IR.
    step("ovl", 1'b1, 1'b1, mk(6, 7, 2, 8'h1C), 1'b1, 2'b00, 1'b1, 4'd6);
    check("ovl_r3", 32'(dut.registers.mem[3]), 32'hF0 ^ 32'h3C);

    // Randomized run
    for (int n = 0; n < 400; n++) begin
      step("rnd",
           ($urandom % 8) != 0,
           ($urandom % 3) == 0,
           18'($urandom),
           ($urandom % 2) == 1,
           2'($urandom),
           ($urandom % 2) == 1,
           4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
